// File: rtl/stc0_ingress_pkg.sv
// stc0_ingress_pkg: shared types and defaults for the stc0 ingress arbiter
package stc0_ingress_pkg;
    typedef enum logic {IDLE, BUSY} state_t;
    localparam int NUM_REQ = 2;
    typedef logic [$clog2(NUM_REQ)-1:0] req_idx_t;
    localparam req_idx_t REQ0 = req_idx_t'(0);
    localparam req_idx_t REQ1 = req_idx_t'(1);
    localparam int STALL_MAX_DEF = 16;
    localparam int STALL_W_DEF = 8;
    localparam int ABORT_W_DEF = 8;
endpackage

// File: rtl/stc0_stall_wdt.sv
// stc0_stall_wdt: idle-cycle watchdog, fires on the MAX-th consecutive increment
module stc0_stall_wdt
    import stc0_ingress_pkg::*;
#(
    parameter int MAX = STALL_MAX_DEF,
    parameter int W = STALL_W_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic fire
);
    logic [W-1:0] cnt;
    assign fire = (MAX != 0) && inc && !clr && (cnt == W'(MAX - 1));
    always_ff @(posedge clk or posedge rst)
        if (rst) cnt <= '0;
        else if (clr || fire) cnt <= '0;
        else if (inc && cnt != '1) cnt <= cnt + W'(1);
endmodule

// File: rtl/stc0_ingress_arb.sv
// stc0_ingress_arb: packet-granular round-robin arbiter onto the stc0_core ingress byte port
module stc0_ingress_arb
    import stc0_ingress_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int STALL_MAX = STALL_MAX_DEF,
    parameter int STALL_W = STALL_W_DEF,
    parameter int ABORT_W = ABORT_W_DEF
) (
    input  logic                ClkIngress,
    input  logic                ARst,
    input  logic                R0Valid,
    input  logic [DATA_W-1:0]   R0Data,
    input  logic                R0Last,
    output logic                R0Ready,
    input  logic                R1Valid,
    input  logic [DATA_W-1:0]   R1Data,
    input  logic                R1Last,
    output logic                R1Ready,
    output logic                IValid,
    output logic [DATA_W-1:0]   ID,
    output logic [NUM_REQ-1:0]  Owner,
    output logic                StallErr,
    output logic [ABORT_W-1:0]  AbortCnt
);
    state_t   state;
    req_idx_t ptr;
    logic     busy, acc0, acc1, acc_last, grant1, fire;
    assign busy = state == BUSY;
    assign R0Ready = busy && Owner[0];
    assign R1Ready = busy && Owner[1];
    assign acc0 = R0Valid && R0Ready;
    assign acc1 = R1Valid && R1Ready;
    assign acc_last = (acc0 && R0Last) || (acc1 && R1Last);
    assign grant1 = R1Valid && (!R0Valid || ptr == REQ1);
    // Any cycle the owner has nothing to offer counts as stall time
    stc0_stall_wdt #(.MAX(STALL_MAX), .W(STALL_W)) u_wdt (
        .clk  (ClkIngress),
        .rst  (ARst),
        .clr  (!busy || acc0 || acc1),
        .inc  (busy && !acc0 && !acc1),
        .fire (fire)
    );
    always_ff @(posedge ClkIngress or posedge ARst)
        if (ARst) begin
            state <= IDLE;
            Owner <= '0;
            ptr <= REQ0;
            IValid <= 1'b0;
            ID <= '0;
            StallErr <= 1'b0;
            AbortCnt <= '0;
        end else begin
            IValid <= acc0 || acc1;
            if (acc0 || acc1) ID <= acc0 ? R0Data : R1Data;
            StallErr <= fire;
            if (fire && AbortCnt != '1) AbortCnt <= AbortCnt + ABORT_W'(1);
            if (!busy && (R0Valid || R1Valid)) begin
                state <= BUSY;
                Owner <= grant1 ? 2'b10 : 2'b01;
            end else if (busy && (acc_last || fire)) begin
                state <= IDLE;
                Owner <= '0;
                ptr <= Owner[0] ? REQ1 : REQ0;
            end
        end
endmodule
